cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the Tomasulo back end. It takes completed results from up to NUM_REQ functional-unit / reservation-station requesters and grants one per cycle. The winner goes out as a registered broadcast (cdb_write, cdb_source, cdb_data) that drives the register file's write, In_source and In_data inputs and the reservation-station snoop ports. Arbitration is round-robin by default, so no unit starves the write-back bus.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one completed result per cycle and registers it as the CDB broadcast.
// Round-robin by default; define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]     req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic                             cdb_write,
    output logic [TAG_WIDTH-1:0]             cdb_source,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic                             bad_tag
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0]   NR   = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [TAG_WIDTH-1:0]  tag_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

    logic [PW-1:0] base;
    logic [PW-1:0] win;
    logic [PW:0]   pos;
    logic          found;
    logic          xfer;

    logic                  cdb_write_q, cdb_write_d;
    logic [TAG_WIDTH-1:0]  cdb_source_q, cdb_source_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic                  bad_tag_q, bad_tag_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_a[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    assign base = rr_ptr_q;
`endif

    // Scan from base upward with wrap; pos never exceeds 2*NUM_REQ-2.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        pos     = '0;
        req_ack = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, base} + (PW+1)'(k);
            if (pos >= NR) begin
                pos = pos - NR;
            end
            if (!found && req_valid[pos[PW-1:0]]) begin
                found = 1'b1;
                win   = pos[PW-1:0];
            end
        end
        if (found && reset_n) begin
            req_ack[win] = 1'b1;
        end
    end

    assign xfer = found & reset_n;

    always_comb begin
        cdb_write_d  = 1'b0;
        cdb_source_d = cdb_source_q;
        cdb_data_d   = cdb_data_q;
        bad_tag_d    = bad_tag_q;
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (xfer) begin
            // Tag 0 means "not redirected": consume it but never broadcast.
            if (tag_a[win] != '0) begin
                cdb_write_d  = 1'b1;
                cdb_source_d = tag_a[win];
                cdb_data_d   = data_a[win];
            end else begin
                bad_tag_d = 1'b1;
            end
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_d = (win == LAST) ? '0 : win + 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_write_q  <= 1'b0;
            cdb_source_q <= '0;
            cdb_data_q   <= '0;
            bad_tag_q    <= 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            cdb_write_q  <= cdb_write_d;
            cdb_source_q <= cdb_source_d;
            cdb_data_q   <= cdb_data_d;
            bad_tag_q    <= bad_tag_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign cdb_write  = cdb_write_q;
    assign cdb_source = cdb_source_q;
    assign cdb_data   = cdb_data_q;
    assign bad_tag    = bad_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a behavioural arbitration model.
module tb_cdb_arbiter;

    localparam int NR = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR*TW-1:0] req_tag;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ack;
    logic             cdb_write;
    logic [TW-1:0]    cdb_source;
    logic [DW-1:0]    cdb_data;
    logic             bad_tag;

    logic [TW-1:0] t_tag  [NR];
    logic [DW-1:0] t_data [NR];

    int total = 0;
    int nbad  = 0;

    int            m_ptr;
    logic          m_write;
    logic          m_bad;
    logic [TW-1:0] m_src;
    logic [DW-1:0] m_data;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_tag[i*TW +: TW]  = t_tag[i];
            req_data[i*DW +: DW] = t_data[i];
        end
    end

    cdb_arbiter #(.NUM_REQ(NR), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_data(req_data),
        .req_ack(req_ack),
        .cdb_write(cdb_write),
        .cdb_source(cdb_source),
        .cdb_data(cdb_data),
        .bad_tag(bad_tag)
    );

    function automatic int pick(input logic [NR-1:0] v);
        int i;
        for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_write = 1'b0;
        m_bad   = 1'b0;
        m_src   = '0;
        m_data  = '0;
    endtask

    task automatic model_edge(input int g);
        m_write = 1'b0;
        if (g >= 0) begin
            if (t_tag[g] != '0) begin
                m_write = 1'b1;
                m_src   = t_tag[g];
                m_data  = t_data[g];
            end else begin
                m_bad = 1'b1;
            end
`ifndef CDB_ARB_FIXED_PRIO_EN
            m_ptr = (g + 1) % NR;
`endif
        end
    endtask

    task automatic advance(input int g);
        @(posedge clock);
        model_edge(g);
        #1;
    endtask

    task automatic test_reset();
        int g;
        reset_n   = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            t_tag[i]  = TW'(i + 1);
            t_data[i] = $urandom;
        end
        model_reset();
        @(posedge clock);
        #2;
        total++;
        if (req_ack !== '0) begin
            nbad++;
            $display("FAIL reset_ack got=%b want=0", req_ack);
        end
        total++;
        if ({cdb_write, cdb_source, cdb_data, bad_tag} !== '0) begin
            nbad++;
            $display("FAIL reset_out got w=%b src=%0d data=%h bad=%b want all 0",
                     cdb_write, cdb_source, cdb_data, bad_tag);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        g = pick(req_valid);
        total++;
        if (req_ack !== 4'b0001) begin
            nbad++;
            $display("FAIL reset_first_grant got=%b want=0001", req_ack);
        end
        advance(g);
        total++;
        if ({cdb_write, cdb_source, cdb_data, bad_tag} !== {m_write, m_src, m_data, m_bad}) begin
            nbad++;
            $display("FAIL reset_bcast got w=%b src=%0d data=%h bad=%b want w=%b src=%0d data=%h bad=%b",
                     cdb_write, cdb_source, cdb_data, bad_tag, m_write, m_src, m_data, m_bad);
        end
        @(negedge clock);
        req_valid = '0;
    endtask

    task automatic test_single();
        int g;
        req_valid = 4'b0100;
        t_tag[2]  = 6'd5;
        t_data[2] = 32'hDEADBEEF;
        #1;
        g = pick(req_valid);
        total++;
        if (req_ack !== oh(g)) begin
            nbad++;
            $display("FAIL single_ack got=%b want=%b", req_ack, oh(g));
        end
        advance(g);
        total++;
        if ({cdb_write, cdb_source, cdb_data} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
            nbad++;
            $display("FAIL single_bcast got w=%b src=%0d data=%h want w=1 src=5 data=deadbeef",
                     cdb_write, cdb_source, cdb_data);
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        total++;
        if (req_ack !== '0) begin
            nbad++;
            $display("FAIL single_idle_ack got=%b want=0", req_ack);
        end
        advance(-1);
        total++;
        if ({cdb_write, cdb_source, cdb_data} !== {1'b0, 6'd5, 32'hDEADBEEF}) begin
            nbad++;
            $display("FAIL single_hold got w=%b src=%0d data=%h want w=0 src=5 data=deadbeef",
                     cdb_write, cdb_source, cdb_data);
        end
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int g;
        req_valid = '1;
        for (int i = 0; i < NR; i++) t_tag[i] = TW'(i + 1);
        for (int c = 0; c < 8; c++) begin
            #1;
            g = pick(req_valid);
            total++;
            if (req_ack !== oh(g)) begin
                nbad++;
                $display("FAIL rr_ack c=%0d got=%b want=%b", c, req_ack, oh(g));
            end
            advance(g);
            total++;
            if ({cdb_write, cdb_source, cdb_data} !== {1'b1, m_src, m_data}) begin
                nbad++;
                $display("FAIL rr_bcast c=%0d got w=%b src=%0d data=%h want w=1 src=%0d data=%h",
                         c, cdb_write, cdb_source, cdb_data, m_src, m_data);
            end
            @(negedge clock);
            if (g >= 0) t_data[g] = $urandom;
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        int g;
        logic [NR-1:0] seq [3];
        seq[0] = 4'b1000;
        seq[1] = 4'b0101;
        seq[2] = 4'b0100;
        for (int i = 0; i < NR; i++) begin
            t_tag[i]  = TW'(10 + i);
            t_data[i] = $urandom;
        end
        for (int s = 0; s < 3; s++) begin
            req_valid = seq[s];
            #1;
            g = pick(req_valid);
            total++;
            if (req_ack !== oh(g)) begin
                nbad++;
                $display("FAIL wrap_ack s=%0d got=%b want=%b", s, req_ack, oh(g));
            end
            advance(g);
            total++;
            if ({cdb_write, cdb_source, cdb_data, bad_tag} !== {m_write, m_src, m_data, m_bad}) begin
                nbad++;
                $display("FAIL wrap_bcast s=%0d got w=%b src=%0d want w=%b src=%0d",
                         s, cdb_write, cdb_source, m_write, m_src);
            end
            @(negedge clock);
        end
        req_valid = '0;
    endtask

    task automatic test_tag0();
        int g;
        req_valid = 4'b0010;
        t_tag[1]  = '0;
        t_data[1] = $urandom;
        #1;
        g = pick(req_valid);
        total++;
        if (req_ack !== 4'b0010) begin
            nbad++;
            $display("FAIL tag0_ack got=%b want=0010", req_ack);
        end
        advance(g);
        @(negedge clock);
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({cdb_write, bad_tag} !== {1'b0, 1'b1}) begin
                nbad++;
                $display("FAIL tag0_sticky c=%0d got w=%b bad=%b want w=0 bad=1",
                         c, cdb_write, bad_tag);
            end
            advance(-1);
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        int g;
        logic [NR-1:0] pend;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    t_tag[i]  = ($urandom_range(0, 15) == 0) ? '0 : TW'($urandom_range(1, 63));
                    t_data[i] = $urandom;
                end
            end
            req_valid = pend;
            #1;
            g = pick(req_valid);
            total++;
            if (req_ack !== oh(g)) begin
                nbad++;
                $display("FAIL rand_ack c=%0d got=%b want=%b", c, req_ack, oh(g));
            end
            advance(g);
            if (g >= 0) pend[g] = 1'b0;
            total++;
            if ({cdb_write, cdb_source, cdb_data, bad_tag} !== {m_write, m_src, m_data, m_bad}) begin
                nbad++;
                $display("FAIL rand_bcast c=%0d got w=%b src=%0d data=%h bad=%b want w=%b src=%0d data=%h bad=%b",
                         c, cdb_write, cdb_source, cdb_data, bad_tag, m_write, m_src, m_data, m_bad);
            end
            @(negedge clock);
        end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        int g;
        req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            t_tag[i]  = TW'(i + 1);
            t_data[i] = $urandom;
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            g = pick(req_valid);
            advance(g);
            @(negedge clock);
        end
        #1;
        g = pick(req_valid);
        advance(g);
        total++;
        if (cdb_write !== m_write) begin
            nbad++;
            $display("FAIL midrst_pre got w=%b want w=%b", cdb_write, m_write);
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({cdb_write, req_ack, bad_tag} !== '0) begin
            nbad++;
            $display("FAIL midrst_drop got w=%b ack=%b bad=%b want all 0",
                     cdb_write, req_ack, bad_tag);
        end
        @(negedge clock);
        req_valid = 4'b1100;
        reset_n   = 1'b1;
        #1;
        g = pick(req_valid);
        total++;
        if (req_ack !== 4'b0100) begin
            nbad++;
            $display("FAIL midrst_grant got=%b want=0100", req_ack);
        end
        advance(g);
        total++;
        if ({cdb_write, cdb_source, cdb_data, bad_tag} !== {m_write, m_src, m_data, m_bad}) begin
            nbad++;
            $display("FAIL midrst_bcast got w=%b src=%0d want w=%b src=%0d",
                     cdb_write, cdb_source, m_write, m_src);
        end
        @(negedge clock);
        req_valid = '0;
    endtask

    initial begin
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            t_tag[i]  = '0;
            t_data[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_tag0();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
